// File: rtl/sparc_pkg.sv
// Shared constants and types for the SPARC pipeline front end.
package sparc_pkg;

  localparam int WORD_W = 32;

  // sethi 0,%g0 : the canonical SPARC no-op used for pipeline bubbles
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0100_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Clear the two low bits of a byte address so it names a whole word.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble-insert controls.
module if_id_reg
  import sparc_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = sparc_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc_in,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc,
  output logic              valid
);

  // Hold has priority; a bubble keeps the PC for traceability but drops valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= NOP_WORD;
      pc    <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      pc <= pc_in;
      if (bubble) begin
        instr <= NOP_WORD;
        valid <= 1'b0;
      end else begin
        instr <= instr_in;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparc_fetch_stage.sv
// SPARC instruction-fetch stage: PC/nPC sequencing with delayed control
// transfer and delay-slot annulment, feeding the IF/ID register.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a sticky misaligned-target
// fault (fetch_fault port and RUN/FAULT state); without it the low target
// bits are silently cleared.
module sparc_fetch_stage
  import sparc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_WORD = sparc_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ct_taken,
  input  logic [WORD_W-1:0] ct_target,
  input  logic              annul_slot,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] PC_IF,
  output logic [WORD_W-1:0] instr_ID,
  output logic [WORD_W-1:0] pc_ID,
  output logic              valid_ID
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] npc;
  logic [WORD_W-1:0] target;
  logic              advance;
  logic              id_hold;
  logic              id_bubble;

`ifdef FETCH_ALIGN_CHECK_EN
  fetch_state_t state;
  fetch_state_t state_next;
  logic         misaligned;

  assign target      = ct_target;
  assign misaligned  = ct_taken && (ct_target[1:0] != 2'b00);
  assign fetch_fault = (state == FAULT);

  // State register: FAULT is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // Next state and fetch controls; a fault freezes PC and streams bubbles.
  always_comb begin
    state_next = state;
    advance    = !stall;
    id_hold    = stall;
    id_bubble  = annul_slot;
    case (state)
      RUN: begin
        if (!stall && misaligned) begin
          state_next = FAULT;
          advance    = 1'b0;
          id_bubble  = 1'b1;
        end
      end
      FAULT: begin
        advance   = 1'b0;
        id_hold   = 1'b0;
        id_bubble = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end
`else
  logic unused_target_bits;

  assign target             = word_align(ct_target);
  assign unused_target_bits = ^ct_target[1:0];

  // Fetch controls: a stall freezes everything and masks ct/annul.
  always_comb begin
    advance   = !stall;
    id_hold   = stall;
    id_bubble = annul_slot;
  end
`endif

  // PC/nPC pair: delayed transfer sends PC to nPC and nPC to the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + 32'd4;
    end else if (advance) begin
      pc  <= npc;
      npc <= ct_taken ? target : npc + 32'd4;
    end
  end

  assign PC_IF     = pc;
  assign imem_addr = pc;

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .hold     (id_hold),
    .bubble   (id_bubble),
    .instr_in (imem_data),
    .pc_in    (pc),
    .instr    (instr_ID),
    .pc       (pc_ID),
    .valid    (valid_ID)
  );

endmodule

// File: tb/tb_sparc_fetch_stage.sv
// Directed testbench for sparc_fetch_stage. ROM word at address A is A ^ 32'hA5A5_0000.
module tb_sparc_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ct_taken;
  logic [31:0] ct_target;
  logic        annul_slot;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] PC_IF;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int passed;
  int total;

  sparc_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .ct_taken   (ct_taken),
    .ct_target  (ct_target),
    .annul_slot (annul_slot),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .PC_IF      (PC_IF),
    .instr_ID   (instr_ID),
    .pc_ID      (pc_ID),
    .valid_ID   (valid_ID)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", name, got, exp);
    else passed++;
  endtask

  // Hold reset across one edge, then release while clk is low.
  task automatic do_reset();
    reset = 1'b0; stall = 0; ct_taken = 0; ct_target = 0; annul_slot = 0;
    tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (PC_IF !== 32'h0) $display("FAIL rst_pc got=%h expected=%h", PC_IF, 32'h0); else passed++;
    total++; if (instr_ID !== 32'h0100_0000) $display("FAIL rst_instr got=%h expected=%h", instr_ID, 32'h0100_0000); else passed++;
    total++; if (pc_ID !== 32'h0) $display("FAIL rst_pcid got=%h expected=%h", pc_ID, 32'h0); else passed++;
    total++; if (valid_ID !== 1'b0) $display("FAIL rst_valid got=%b expected=0", valid_ID); else passed++;
  endtask

  task automatic test_free_run();
    do_reset();
    tick();
    total++; if (PC_IF !== 32'd4) $display("FAIL run_pc1 got=%h expected=%h", PC_IF, 32'd4); else passed++;
    total++; if (instr_ID !== 32'hA5A5_0000) $display("FAIL run_instr1 got=%h expected=%h", instr_ID, 32'hA5A5_0000); else passed++;
    total++; if (pc_ID !== 32'd0) $display("FAIL run_pcid1 got=%h expected=%h", pc_ID, 32'd0); else passed++;
    total++; if (valid_ID !== 1'b1) $display("FAIL run_valid1 got=%b expected=1", valid_ID); else passed++;
    tick();
    total++; if (PC_IF !== 32'd8) $display("FAIL run_pc2 got=%h expected=%h", PC_IF, 32'd8); else passed++;
    tick();
    total++; if (PC_IF !== 32'd12) $display("FAIL run_pc3 got=%h expected=%h", PC_IF, 32'd12); else passed++;
    total++; if (instr_ID !== 32'hA5A5_0008) $display("FAIL run_instr3 got=%h expected=%h", instr_ID, 32'hA5A5_0008); else passed++;
    tick();
    total++; if (PC_IF !== 32'd16) $display("FAIL run_pc4 got=%h expected=%h", PC_IF, 32'd16); else passed++;
    total++; if (pc_ID !== 32'd12) $display("FAIL run_pcid4 got=%h expected=%h", pc_ID, 32'd12); else passed++;
  endtask

  task automatic test_ct_taken();
    do_reset();
    tick(); tick();
    ct_taken = 1; ct_target = 32'd40;
    tick();
    ct_taken = 0;
    total++; if (PC_IF !== 32'd12) $display("FAIL ct_pc1 got=%h expected=%h", PC_IF, 32'd12); else passed++;
    total++; if (instr_ID !== 32'hA5A5_0008) $display("FAIL ct_slot_instr got=%h expected=%h", instr_ID, 32'hA5A5_0008); else passed++;
    total++; if (valid_ID !== 1'b1) $display("FAIL ct_slot_valid got=%b expected=1", valid_ID); else passed++;
    tick();
    total++; if (PC_IF !== 32'd40) $display("FAIL ct_pc2 got=%h expected=%h", PC_IF, 32'd40); else passed++;
    tick();
    total++; if (PC_IF !== 32'd44) $display("FAIL ct_pc3 got=%h expected=%h", PC_IF, 32'd44); else passed++;
    total++; if (instr_ID !== 32'hA5A5_0028) $display("FAIL ct_tgt_instr got=%h expected=%h", instr_ID, 32'hA5A5_0028); else passed++;
  endtask

  task automatic test_annul();
    do_reset();
    tick(); tick();
    ct_taken = 1; ct_target = 32'd40; annul_slot = 1;
    tick();
    ct_taken = 0; annul_slot = 0;
    total++; if (PC_IF !== 32'd12) $display("FAIL an_pc1 got=%h expected=%h", PC_IF, 32'd12); else passed++;
    total++; if (instr_ID !== 32'h0100_0000) $display("FAIL an_instr got=%h expected=%h", instr_ID, 32'h0100_0000); else passed++;
    total++; if (valid_ID !== 1'b0) $display("FAIL an_valid got=%b expected=0", valid_ID); else passed++;
    total++; if (pc_ID !== 32'd8) $display("FAIL an_pcid got=%h expected=%h", pc_ID, 32'd8); else passed++;
    tick();
    total++; if (PC_IF !== 32'd40) $display("FAIL an_pc2 got=%h expected=%h", PC_IF, 32'd40); else passed++;
    total++; if (valid_ID !== 1'b1) $display("FAIL an_valid2 got=%b expected=1", valid_ID); else passed++;
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    tick(); tick(); tick(); tick();
    stall = 1; ct_taken = 1; ct_target = 32'd40; annul_slot = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_pc", PC_IF, 32'd16);
      chk("st_instr", instr_ID, 32'hA5A5_000C);
      chk("st_pcid", pc_ID, 32'd12);
    end
    stall = 0; ct_taken = 0; annul_slot = 0;
    tick();
    total++; if (PC_IF !== 32'd20) $display("FAIL st_resume got=%h expected=%h", PC_IF, 32'd20); else passed++;
    total++; if (instr_ID !== 32'hA5A5_0010) $display("FAIL st_resume_instr got=%h expected=%h", instr_ID, 32'hA5A5_0010); else passed++;
    tick();
    total++; if (PC_IF !== 32'd24) $display("FAIL mr_pre got=%h expected=%h", PC_IF, 32'd24); else passed++;
    #1 reset = 1'b0;
    #1;
    total++; if (PC_IF !== 32'd0) $display("FAIL mr_pc got=%h expected=%h", PC_IF, 32'd0); else passed++;
    total++; if (valid_ID !== 1'b0) $display("FAIL mr_valid got=%b expected=0", valid_ID); else passed++;
    total++; if (instr_ID !== 32'h0100_0000) $display("FAIL mr_instr got=%h expected=%h", instr_ID, 32'h0100_0000); else passed++;
    #1 reset = 1'b1;
    tick();
    total++; if (PC_IF !== 32'd4) $display("FAIL mr_after got=%h expected=%h", PC_IF, 32'd4); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    tick(); tick();
    ct_taken = 1; ct_target = 32'hFFFF_FFFC;
    tick();
    ct_taken = 0;
    tick();
    total++; if (PC_IF !== 32'hFFFF_FFFC) $display("FAIL wr_top got=%h expected=%h", PC_IF, 32'hFFFF_FFFC); else passed++;
    tick();
    total++; if (PC_IF !== 32'h0) $display("FAIL wr_zero got=%h expected=%h", PC_IF, 32'h0); else passed++;
    total++; if (instr_ID !== 32'h5A5A_FFFC) $display("FAIL wr_instr got=%h expected=%h", instr_ID, 32'h5A5A_FFFC); else passed++;
    tick();
    total++; if (PC_IF !== 32'd4) $display("FAIL wr_next got=%h expected=%h", PC_IF, 32'd4); else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    tick(); tick();
    ct_taken = 1; ct_target = 32'd42;
    tick();
    ct_taken = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (fetch_fault !== 1'b1) $display("FAIL ma_fault got=%b expected=1", fetch_fault); else passed++;
    for (int i = 0; i < 3; i++) begin
      chk("ma_pc_frozen", PC_IF, 32'd8);
      chk("ma_bubble", {31'd0, valid_ID}, 32'd0);
      stall = (i == 1);
      tick();
    end
    stall = 0;
`else
    total++; if (PC_IF !== 32'd12) $display("FAIL ma_pc1 got=%h expected=%h", PC_IF, 32'd12); else passed++;
    tick();
    total++; if (PC_IF !== 32'd40) $display("FAIL ma_pc2 got=%h expected=%h", PC_IF, 32'd40); else passed++;
`endif
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_free_run();
    test_ct_taken();
    test_annul();
    test_stall_and_reset();
    test_wrap();
    test_misaligned();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sparc_fetch_stage.md
# sparc_fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the SPARC pipelined processor unit. It holds the architectural PC/nPC pair and drives the instruction-memory address. It latches the fetched word into the IF/ID register and implements SPARC delayed control transfer, including delay-slot annulment. It also accepts stall requests from the hazard logic. It sits directly upstream of the decode stage and register file, which consume `instr_ID`, `pc_ID` and `valid_ID`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. nPC resets to `RESET_PC+4`.
- `NOP_WORD`, default 32'h0100_0000: word driven on `instr_ID` for bubbles (`sethi 0,%g0`).
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC, nPC and IF/ID (load-use hazard from decode).
- `ct_taken` in 1: control transfer resolved taken in ID this cycle (Bicc/CALL/JMPL).
- `ct_target` in 32: byte address of the transfer target.
- `annul_slot` in 1: squash the instruction currently in IF (the delay slot).
- `imem_addr` out 32: byte address to instruction ROM. Equals `PC_IF`.
- `imem_data` in 32: big-endian word read combinationally from ROM at `imem_addr`.
- `PC_IF` out 32: current fetch PC.
- `instr_ID` out 32: IF/ID instruction register.
- `pc_ID` out 32: PC of the instruction in `instr_ID`.
- `valid_ID` out 1: `instr_ID` is a real instruction. When low, decode treats `instr_ID` as a NOP.
- `fetch_fault` out 1: sticky misaligned-target flag. Present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- State: `PC`, `nPC`, IF/ID register {`instr_ID`, `pc_ID`, `valid_ID`}, plus a one-bit `state` (RUN/FAULT) when the alignment check is compiled in.
- Priority on each rising edge: reset > `stall` > `ct_taken`/`annul_slot` > sequential.
- Reset values:
  - `PC=RESET_PC`, `nPC=RESET_PC+4`
  - `instr_ID=NOP_WORD`, `pc_ID=0`, `valid_ID=0`
  - `fetch_fault=0`, state RUN
- Sequential (no stall, no ct, no annul):
  - `PC<=nPC`, `nPC<=nPC+4`
  - `instr_ID<=imem_data`, `pc_ID<=PC`, `valid_ID<=1`
- `stall=1`: PC, nPC and IF/ID all hold. `ct_taken` and `annul_slot` are ignored, because decode has not resolved the transfer. The decode stage re-asserts them after the stall releases.
- `ct_taken=1`:
  - `PC<=nPC`, which fetches the instruction after the delay slot. `nPC<=ct_target`.
  - The delay slot currently in IF is latched normally unless `annul_slot=1`.
- `annul_slot=1`:
  - IF/ID loads a bubble: `instr_ID<=NOP_WORD`, `pc_ID<=PC`, `valid_ID<=0`.
  - PC/nPC advance as in the sequential case or the `ct_taken` case.
  - This covers both taken `ba,a` and untaken conditional `,a`.
- Address arithmetic is modulo 2^32. nPC+4 wraps from 32'hFFFF_FFFC to 0 with no flag.
- `ct_target[1:0]` is forced to 00 when `FETCH_ALIGN_CHECK_EN` is not defined.

## Timing
- Fetch latency: the instruction at address A appears on `instr_ID` one edge after `PC_IF==A`, if not stalled.
- The taken transfer, resolved in ID at edge N, appears on `PC_IF` two edges later, after the delay slot.
- The first valid instruction reaches ID on the first edge after reset deasserts.
- Asserting `reset` mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.
- `imem_addr` changes only after edges and after reset, so it is glitch-free relative to `clk`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined, and `ct_taken=1` with `ct_target[1:0]!=0` (not stalled):
  - `fetch_fault<=1` and the state moves to FAULT.
  - PC/nPC freeze at their current values.
  - IF/ID loads bubbles every cycle until reset.
  - `stall` has no effect while in FAULT.
- `FETCH_ALIGN_CHECK_EN` undefined: no `fetch_fault` port and no FAULT state. The low target bits are zeroed silently.

## Structure
- A shared package `sparc_pkg` holds:
  - `NOP_WORD`
  - the word/address width constant (32)
  - the `fetch_state_t` enum {RUN, FAULT}
- One natural sub-module, `if_id_reg`, is the IF/ID register with hold and bubble-insert controls. PC/nPC sequencing stays in the top.

## Test plan
- Reset, then free run with ROM words W0..W3 at 0,4,8,12 -> `PC_IF` 0,4,8,12,16 on successive edges. `instr_ID=W0` with `pc_ID=0` and `valid_ID=1` after edge 1.
- At `PC_IF=8`, `ct_taken=1` with `ct_target=40` -> next `PC_IF` values 12, 40, 44. The instruction at 8 reaches ID valid (delay slot executes).
- Same as above with `annul_slot=1` -> ID gets `NOP_WORD`, `valid_ID=0` and `pc_ID=8`. `PC_IF` follows 12, 40.
- `stall=1` for 2 cycles while `ct_taken=1` at `PC_IF=16` -> PC/IF/ID hold 2 cycles and ct is ignored. After release the sequence resumes at 20.
- Pulse `reset` low mid-run at `PC_IF=24` -> outputs immediately become `PC_IF=0`, `valid_ID=0`, `instr_ID=32'h0100_0000`.
- With `FETCH_ALIGN_CHECK_EN`, `ct_target=42` -> `fetch_fault=1`, `PC_IF` frozen and `valid_ID=0` until reset. Without the macro, the same stimulus fetches at 40.
